// File: rtl/accel_hex_display.sv
// accel_hex_display
//   Display stage for accelerometer samples. Accepts one signed 16-bit sample
//   per valid/ready handshake. Its magnitude is converted to five BCD digits by
//   a 16-iteration double-dabble. The result drives six 7-segment digits:
//   HEX5 = sign, HEX4..HEX0 = magnitude, with optional leading-zero blanking.
//   All outputs are registered and change only on the encode edge, which comes
//   17 clocks after the accepting edge.
//
// Parameters
//   LEADING_ZERO_BLANK : 1 blanks non-significant zeros on HEX4..HEX1.
//   SEG_ACTIVE_LOW     : 1 = a segment bit of 0 lights the segment; 0 inverts.
//   BAR_SHIFT          : magnitude right-shift for the LED bar graph.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   synchronous active-low reset
//   sample_valid   in   sample_data is valid
//   sample_data    in   signed 16-bit sample
//   sample_ready   out  high when idle and out of reset
//   hex0..5_export out  7-bit segment patterns, bit order gfedcba
//   led_export     out  10-bit bar graph (only with ACCEL_HEX_LED_BAR_EN)
//
// Optional feature macro: ACCEL_HEX_LED_BAR_EN
module accel_hex_display #(
  parameter int LEADING_ZERO_BLANK = 1,
  parameter int SEG_ACTIVE_LOW     = 1,
  parameter int BAR_SHIFT          = 5
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_data,
  output logic               sample_ready,
  output logic [6:0]         hex0_export,
  output logic [6:0]         hex1_export,
  output logic [6:0]         hex2_export,
  output logic [6:0]         hex3_export,
  output logic [6:0]         hex4_export,
  output logic [6:0]         hex5_export
`ifdef ACCEL_HEX_LED_BAR_EN
  ,
  output logic [9:0]         led_export
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SEG   = 2'd2
  } state_t;

  localparam logic [6:0] BLANK_RAW = 7'h7F;
  localparam logic [6:0] MINUS_RAW = 7'h3F;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        shift_en;
  logic        seg_en;
  logic [3:0]  cnt;
  logic        sign;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [15:0] mag_in;
  logic [4:1]  blank_d;
  logic [6:0]  seg_next [6];
`ifdef ACCEL_HEX_LED_BAR_EN
  logic [15:0] mag_hold;
`endif

  // Board polarity: patterns are built active-low and inverted if needed.
  function automatic logic [6:0] seg_pol(input logic [6:0] p);
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return BLANK_RAW;
    endcase
  endfunction

  // Add 3 to every nibble >= 5 before the shift, so that each nibble carries
  // correctly into the next decimal place.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return r;
  endfunction

  // Saturating bar fill: n = min(10, m >> BAR_SHIFT), result = (1<<n)-1.
  function automatic logic [9:0] bar_fill(input logic [15:0] m);
    logic [15:0] lvl;
    lvl = m >> BAR_SHIFT;
    if (lvl >= 16'd10) return 10'h3FF;
    return 10'((11'd1 << lvl[3:0]) - 11'd1);
  endfunction

  // |sample| fits 16 unsigned bits: -32768 negates to 16'h8000 = 32768.
  assign mag_in = sample_data[15] ? 16'(-sample_data) : 16'(sample_data);

  assign sample_ready = (state == IDLE) && reset_reset_n;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    seg_en     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid && sample_ready) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == 4'd15) state_next = SEG;
      end
      SEG: begin
        seg_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit encode: a digit k (4..1) blanks only if it and every higher digit are 0.
  always_comb begin
    blank_d[4] = (LEADING_ZERO_BLANK != 0) && (bcd[19:16] == 4'd0);
    blank_d[3] = blank_d[4] && (bcd[15:12] == 4'd0);
    blank_d[2] = blank_d[3] && (bcd[11:8]  == 4'd0);
    blank_d[1] = blank_d[2] && (bcd[7:4]   == 4'd0);
    seg_next[0] = seg_pol(seg_digit(bcd[3:0]));
    for (int k = 1; k < 5; k++) begin
      seg_next[k] = blank_d[k] ? seg_pol(BLANK_RAW) : seg_pol(seg_digit(bcd[4*k +: 4]));
    end
    seg_next[5] = (sign && (bcd != 20'd0)) ? seg_pol(MINUS_RAW) : seg_pol(BLANK_RAW);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt         <= 4'd0;
      sign        <= 1'b0;
      mag         <= 16'd0;
      bcd         <= 20'd0;
      hex0_export <= seg_pol(BLANK_RAW);
      hex1_export <= seg_pol(BLANK_RAW);
      hex2_export <= seg_pol(BLANK_RAW);
      hex3_export <= seg_pol(BLANK_RAW);
      hex4_export <= seg_pol(BLANK_RAW);
      hex5_export <= seg_pol(BLANK_RAW);
`ifdef ACCEL_HEX_LED_BAR_EN
      mag_hold    <= 16'd0;
      led_export  <= 10'd0;
`endif
    end else begin
      // capture
      if (accept) begin
        sign <= sample_data[15];
        mag  <= mag_in;
        bcd  <= 20'd0;
        cnt  <= 4'd0;
`ifdef ACCEL_HEX_LED_BAR_EN
        mag_hold <= mag_in;
`endif
      end
      // shift-add-3
      if (shift_en) begin
        {bcd, mag} <= {dd_adjust(bcd), mag} << 1;
        cnt        <= cnt + 4'd1;
      end
      // segment register update
      if (seg_en) begin
        hex0_export <= seg_next[0];
        hex1_export <= seg_next[1];
        hex2_export <= seg_next[2];
        hex3_export <= seg_next[3];
        hex4_export <= seg_next[4];
        hex5_export <= seg_next[5];
`ifdef ACCEL_HEX_LED_BAR_EN
        led_export  <= bar_fill(mag_hold);
`endif
      end
    end
  end

endmodule

// File: tb/tb_accel_hex_display.sv
// Testbench for accel_hex_display. Two instances share the stimulus: one with
// leading-zero blanking enabled, one with it disabled. Expected segment
// patterns come from a decimal reference model (divide/modulo on the integer
// sample value).
module tb_accel_hex_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               valid;
  logic signed [15:0] data;
  logic               ready1, ready0;
  logic [6:0]         h1 [6];
  logic [6:0]         h0 [6];
`ifdef ACCEL_HEX_LED_BAR_EN
  logic [9:0]         led1, led0;
`endif

  accel_hex_display #(.LEADING_ZERO_BLANK(1), .SEG_ACTIVE_LOW(1), .BAR_SHIFT(5)) dut1 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sample_valid  (valid),
    .sample_data   (data),
    .sample_ready  (ready1),
    .hex0_export   (h1[0]),
    .hex1_export   (h1[1]),
    .hex2_export   (h1[2]),
    .hex3_export   (h1[3]),
    .hex4_export   (h1[4]),
    .hex5_export   (h1[5])
`ifdef ACCEL_HEX_LED_BAR_EN
    ,
    .led_export    (led1)
`endif
  );

  accel_hex_display #(.LEADING_ZERO_BLANK(0), .SEG_ACTIVE_LOW(1), .BAR_SHIFT(5)) dut0 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sample_valid  (valid),
    .sample_data   (data),
    .sample_ready  (ready0),
    .hex0_export   (h0[0]),
    .hex1_export   (h0[1]),
    .hex2_export   (h0[2]),
    .hex3_export   (h0[3]),
    .hex4_export   (h0[4]),
    .hex5_export   (h0[5])
`ifdef ACCEL_HEX_LED_BAR_EN
    ,
    .led_export    (led0)
`endif
  );

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp1 [6];
  logic [6:0] exp0 [6];
  logic [9:0] exp_led;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: decimal digit at position pos of |v|, blank if lzb and |v| < 10^pos.
  function automatic logic [6:0] model_seg(input int v, input int pos, input bit lzb);
    int m;
    int p10;
    m   = (v < 0) ? -v : v;
    p10 = 1;
    for (int k = 0; k < pos; k++) p10 = p10 * 10;
    if (pos == 5) return (v < 0) ? 7'h3F : 7'h7F;
    if (lzb && pos > 0 && m < p10) return 7'h7F;
    return SEG_TAB[(m / p10) % 10];
  endfunction

  function automatic logic [9:0] model_led(input int v);
    int m;
    int n;
    m = (v < 0) ? -v : v;
    n = m / 32;
    if (n > 10) n = 10;
    return 10'((1 << n) - 1);
  endfunction

  task automatic set_expected(input int v);
    for (int k = 0; k < 6; k++) begin
      exp1[k] = model_seg(v, k, 1'b1);
      exp0[k] = model_seg(v, k, 1'b0);
    end
    exp_led = model_led(v);
  endtask

  task automatic set_blank();
    for (int k = 0; k < 6; k++) begin
      exp1[k] = 7'h7F;
      exp0[k] = 7'h7F;
    end
    exp_led = 10'd0;
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("%s_lzb1_hex%0d", tag, k), int'(h1[k]), int'(exp1[k]));
      check_val($sformatf("%s_lzb0_hex%0d", tag, k), int'(h0[k]), int'(exp0[k]));
    end
`ifdef ACCEL_HEX_LED_BAR_EN
    check_val({tag, "_led1"}, int'(led1), int'(exp_led));
    check_val({tag, "_led0"}, int'(led0), int'(exp_led));
`endif
  endtask

  task automatic check_ready(input string tag, input bit want);
    check_val({tag, "_ready1"}, int'(ready1), int'(want));
    check_val({tag, "_ready0"}, int'(ready0), int'(want));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Busy window: after the accepting edge and each of the next 16 edges the
  // outputs must hold and ready must be low; returns just after edge N+17.
  task automatic busy_window(input string tag, input bit hold_valid, input int next_v);
    for (int i = 0; i < 17; i++) begin
      check_ready({tag, "_busy"}, 1'b0);
      compare_all({tag, "_hold"});
      if (hold_valid) begin
        valid = 1'b1;
        data  = 16'(next_v);
      end else begin
        valid = 1'($urandom_range(0, 1));
        data  = 16'($urandom);
      end
      tick();
    end
    if (!hold_valid) valid = 1'b0;
  endtask

  task automatic run_sample(input int v);
    valid = 1'b1;
    data  = 16'(v);
    check_ready($sformatf("pre_%0d", v), 1'b1);
    tick();
    busy_window($sformatf("s%0d", v), 1'b0, 0);
    set_expected(v);
    compare_all($sformatf("res_%0d", v));
    check_ready($sformatf("post_%0d", v), 1'b1);
  endtask

  initial begin
    int dir_vals [15] = '{1234, -32768, 0, 32767, -1, 9, 10, 99, 100, 1000,
                          10000, -200, 200, 31, -32767};
    logic [15:0] r;
    int va, vb, vc;

    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    @(negedge clk);
    set_blank();
    repeat (3) begin
      tick();
      check_ready("reset", 1'b0);
      compare_all("reset");
    end
    rst_n = 1'b1;
    tick();
    check_ready("after_reset", 1'b1);
    compare_all("after_reset");

    foreach (dir_vals[i]) run_sample(dir_vals[i]);

    repeat (25) begin
      r = 16'($urandom);
      run_sample(int'($signed(r)));
      repeat ($urandom_range(0, 3)) begin
        tick();
        compare_all("gap");
      end
    end

    // valid held high across two conversions, then reset mid-conversion
    r  = 16'($urandom);
    va = int'($signed(r));
    r  = 16'($urandom);
    vb = int'($signed(r));
    r  = 16'($urandom);
    vc = int'($signed(r));
    valid = 1'b1;
    data  = 16'(va);
    check_ready("b2b_pre", 1'b1);
    tick();
    busy_window("b2b_a", 1'b1, vb);
    set_expected(va);
    compare_all("b2b_a_res");
    check_ready("b2b_a_post", 1'b1);
    tick();
    busy_window("b2b_b", 1'b1, vc);
    set_expected(vb);
    compare_all("b2b_b_res");
    check_ready("b2b_b_post", 1'b1);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_ready("abort_busy", 1'b0);
      compare_all("abort_pre");
      tick();
    end
    rst_n = 1'b0;
    tick();
    set_blank();
    compare_all("abort");
    check_ready("abort_in_reset", 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      compare_all("abort_hold");
      check_ready("abort_idle", 1'b1);
    end
    run_sample(-4321);
    run_sample(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
